// File: rtl/vme_dword_master.sv
// Splits one 64-bit request into two 32-bit slave accesses, high word first; 4+ cycles accept-to-response.
// Backpressure: req_ready only in IDLE, one transaction in flight; per-word timeout bounds slave stalls.
module vme_dword_master #(
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:2] req_addr,
  input  logic [63:0]   req_wdata,
  output logic          rsp_valid,
  output logic [63:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:2] VMEAddr,
  output logic [31:0]   VMEWrData,
  input  logic [31:0]   VMERdData,
  output logic          VMERdMem,
  output logic          VMEWrMem,
  input  logic          VMERdDone,
  input  logic          VMEWrDone
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HI_STRB = 3'd1,
    HI_WAIT = 3'd2,
    LO_STRB = 3'd3,
    LO_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic            wr_q;
  logic [AW-1:2]   addr_q;
  logic [63:0]     wdata_q;
  logic [63:0]     rdata_q;
  logic [7:0]      cnt_q;

  logic            accept;
  logic            done;
  logic            timeout;
  logic            in_hi, in_lo, in_wait;

  // Next-cycle values for the registered outputs and datapath
  logic            wr_src;
  logic [AW-1:2]   addr_src;
  logic [63:0]     wdata_src;
  logic [AW-1:2]   addr_d;
  logic [31:0]     wrdata_d;
  logic            rd_mem_d, wr_mem_d;
  logic            rsp_valid_d, rsp_err_d;
  logic [63:0]     rsp_rdata_d;
  logic [63:0]     rdata_nxt;
  logic [7:0]      cnt_d;

  assign req_ready = (state == IDLE) & ~Rst;
  assign accept    = req_valid & req_ready;
  // Only the acknowledge matching the latched direction is ever honoured
  assign done      = wr_q ? VMEWrDone : VMERdDone;
  assign timeout   = (cnt_q == 8'(TIMEOUT - 1));
  assign in_hi     = (state == HI_STRB) | (state == HI_WAIT);
  assign in_lo     = (state == LO_STRB) | (state == LO_WAIT);
  assign in_wait   = (state == HI_WAIT) | (state == LO_WAIT);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      VMEAddr   <= '0;
      VMEWrData <= '0;
      VMERdMem  <= 1'b0;
      VMEWrMem  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      rdata_q   <= rdata_nxt;
      cnt_q     <= cnt_d;
      VMEAddr   <= addr_d;
      VMEWrData <= wrdata_d;
      VMERdMem  <= rd_mem_d;
      VMEWrMem  <= wr_mem_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HI_STRB;
      HI_STRB: state_nxt = done ? LO_STRB : HI_WAIT;
      HI_WAIT: begin
        if (done)         state_nxt = LO_STRB;
        else if (timeout) state_nxt = RESP;
      end
      LO_STRB: state_nxt = done ? RESP : LO_WAIT;
      LO_WAIT: begin
        if (done || timeout) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state; in the
  // accept cycle the request fields bypass the not-yet-loaded latches.
  always_comb begin
    wr_src    = (state == IDLE) ? req_write : wr_q;
    addr_src  = (state == IDLE) ? req_addr  : addr_q;
    wdata_src = (state == IDLE) ? req_wdata : wdata_q;

    rdata_nxt = rdata_q;
    if (accept) begin
      rdata_nxt = '0;
    end else if (done && !wr_q) begin
      if (in_hi) rdata_nxt[63:32] = VMERdData;
      if (in_lo) rdata_nxt[31:0]  = VMERdData;
    end

    addr_d   = VMEAddr;
    wrdata_d = VMEWrData;
    if (state_nxt == HI_STRB) begin
      addr_d    = addr_src;
      addr_d[2] = 1'b0;
      wrdata_d  = wdata_src[63:32];
    end else if (state_nxt == LO_STRB) begin
      addr_d    = addr_src;
      addr_d[2] = 1'b1;
      wrdata_d  = wdata_src[31:0];
    end

    rd_mem_d = ((state_nxt == HI_STRB) || (state_nxt == LO_STRB)) && !wr_src;
    wr_mem_d = ((state_nxt == HI_STRB) || (state_nxt == LO_STRB)) &&  wr_src;

    cnt_d = '0;
    if (in_wait) cnt_d = cnt_q + 8'd1;

    rsp_valid_d = (state_nxt == RESP);
    rsp_err_d   = in_wait && !done && timeout;
    rsp_rdata_d = (state_nxt == RESP) ? rdata_nxt : 64'd0;
  end

endmodule

// File: tb/tb_vme_dword_master.sv
// Directed bench for vme_dword_master with a latency-programmable slave model and
// a strobe/response scoreboard checked on the falling clock edge.
module tb_vme_dword_master;
  localparam int AW      = 4;
  localparam int TIMEOUT = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:2] req_addr;
  logic [63:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [63:0]   rsp_rdata;
  logic [AW-1:2] VMEAddr;
  logic [31:0]   VMEWrData, VMERdData;
  logic          VMERdMem, VMEWrMem;
  logic          VMERdDone, VMEWrDone;

  vme_dword_master #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData), .VMERdData(VMERdData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Slave model: acknowledges a strobe after a programmable number of cycles
  logic [31:0]   mem [4];
  int            wr_lat, rd_lat, acks_left;
  int            pend;
  logic          pend_wr;
  logic [AW-1:2] pend_addr;
  logic          slv_rd_done, slv_wr_done, inj_rd, inj_wr;
  logic [31:0]   slv_rdata;

  assign VMERdDone = slv_rd_done | inj_rd;
  assign VMEWrDone = slv_wr_done | inj_wr;
  assign VMERdData = slv_rdata;

  always @(negedge Clk) begin
    slv_rd_done = 1'b0;
    slv_wr_done = 1'b0;
    if (Rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pend_wr) slv_wr_done = 1'b1;
          else begin
            slv_rd_done = 1'b1;
            slv_rdata   = mem[pend_addr];
          end
        end
      end
      if ((VMERdMem || VMEWrMem) && acks_left != 0) begin
        pend_wr   = VMEWrMem;
        pend_addr = VMEAddr;
        pend      = VMEWrMem ? wr_lat : rd_lat;
        if (acks_left > 0) acks_left--;
      end
    end
  end

  // Scoreboard
  typedef struct {
    int            cyc;
    logic          wr;
    logic [AW-1:2] addr;
    logic [31:0]   dat;
  } strb_t;
  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] rdata;
  } rsp_t;

  strb_t strb_q[$];
  rsp_t  rsp_q[$];
  strb_t se;
  rsp_t  re;
  int    last_rsp_cyc = -100;

  always @(negedge Clk) begin
    if (VMERdMem || VMEWrMem) begin
      chk("one_strobe", 64'(VMERdMem & VMEWrMem), 64'd0);
      if (strb_q.size() == 0) begin
        chk("unexp_strobe", 64'({VMERdMem, VMEWrMem}), 64'd0);
      end else begin
        se = strb_q.pop_front();
        chk("strobe_cycle", 64'(cyc), 64'(se.cyc));
        chk("strobe_dir", 64'(VMEWrMem), 64'(se.wr));
        chk("strobe_addr", 64'(VMEAddr), 64'(se.addr));
        if (se.wr) chk("strobe_wdata", 64'(VMEWrData), 64'(se.dat));
      end
    end
    if (rsp_valid) begin
      last_rsp_cyc = cyc;
      if (rsp_q.size() == 0) begin
        chk("unexp_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        re = rsp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(re.cyc));
        chk("rsp_err", 64'(rsp_err), 64'(re.err));
        chk("rsp_rdata", rsp_rdata, re.rdata);
      end
    end
  end

  function automatic void push_strb(input int c, input logic wr, input logic [AW-1:2] a, input logic [31:0] d);
    strb_t s;
    s.cyc = c; s.wr = wr; s.addr = a; s.dat = d;
    strb_q.push_back(s);
  endfunction

  function automatic void push_rsp(input int c, input logic err, input logic [63:0] d);
    rsp_t r;
    r.cyc = c; r.err = err; r.rdata = d;
    rsp_q.push_back(r);
  endfunction

  // Expected traffic for a transaction against the slave model with no timeout
  function automatic void push_norm(input int t, input logic wr, input logic [AW-1:2] a, input logic [63:0] d);
    logic [AW-1:2] ahi, alo;
    int l;
    ahi = a; ahi[2] = 1'b0;
    alo = a; alo[2] = 1'b1;
    l = wr ? wr_lat : rd_lat;
    push_strb(t + 1, wr, ahi, d[63:32]);
    push_strb(t + l + 2, wr, alo, d[31:0]);
    push_rsp(t + 2 * l + 3, 1'b0, wr ? 64'd0 : {mem[ahi], mem[alo]});
  endfunction

  task automatic send(input logic wr, input logic [AW-1:2] a, input logic [63:0] d, output int t);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    #1;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        t = cyc;
        break;
      end
      @(negedge Clk); #1;
    end
    if (t < 0) chk("accept_bound", 64'(req_ready), 64'd1);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (strb_q.size() == 0 && rsp_q.size() == 0) break;
      @(negedge Clk);
    end
    chk("drain", 64'(strb_q.size() + rsp_q.size()), 64'd0);
    strb_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, r;
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h01234567;
    mem[2] = 32'hA5A50F0F; mem[3] = 32'h13579BDF;
    wr_lat = 2; rd_lat = 1; acks_left = -1; pend = 0;
    slv_rd_done = 1'b0; slv_wr_done = 1'b0; slv_rdata = '0;
    inj_rd = 1'b0; inj_wr = 1'b0;
    Rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(negedge Clk);
    chk("reset_strobes", 64'({VMERdMem, VMEWrMem}), 64'd0);
    chk("reset_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    chk("reset_addr", 64'(VMEAddr), 64'd0);
    chk("reset_wdata", 64'(VMEWrData), 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    chk("reset_ready_in_rst", 64'(req_ready), 64'd0);
    Rst = 1'b0; #1;
    chk("reset_ready", 64'(req_ready), 64'd1);

    // Write against a 2-cycle-ack slave
    @(negedge Clk);
    send(1'b1, 2'd0, 64'h1122334455667788, t);
    push_strb(t + 1, 1'b1, 2'd0, 32'h11223344);
    push_strb(t + 4, 1'b1, 2'd1, 32'h55667788);
    push_rsp(t + 7, 1'b0, 64'd0);
    @(negedge Clk); req_valid = 1'b0;
    wait_drain(40);

    // Read against a 1-cycle-ack slave
    @(negedge Clk);
    send(1'b0, 2'd0, 64'd0, t);
    push_strb(t + 1, 1'b0, 2'd0, 32'd0);
    push_strb(t + 3, 1'b0, 2'd1, 32'd0);
    push_rsp(t + 5, 1'b0, 64'hDEADBEEF01234567);
    @(negedge Clk); req_valid = 1'b0;
    wait_drain(40);

    // Address bit 2 set in the request is ignored
    @(negedge Clk);
    send(1'b0, 2'd3, 64'd0, t);
    push_norm(t, 1'b0, 2'd3, 64'd0);
    @(negedge Clk); req_valid = 1'b0;
    wait_drain(40);

    // HI word timeout; the slave's very late ack lands after the response
    rd_lat = 20;
    @(negedge Clk);
    send(1'b0, 2'd0, 64'd0, t);
    push_strb(t + 1, 1'b0, 2'd0, 32'd0);
    push_rsp(t + 1 + TIMEOUT + 1, 1'b1, 64'd0);
    @(negedge Clk); req_valid = 1'b0;
    wait_drain(60);
    for (int i = 0; i < 6; i++) begin
      inj_wr = (i == 1);
      @(negedge Clk);
      chk("late_done_ready", 64'(req_ready), 64'd1);
    end
    inj_wr = 1'b0;
    rd_lat = 1;

    // LO word timeout keeps the captured HI word
    acks_left = 1;
    @(negedge Clk);
    send(1'b0, 2'd2, 64'd0, t);
    push_strb(t + 1, 1'b0, 2'd2, 32'd0);
    push_strb(t + 3, 1'b0, 2'd3, 32'd0);
    push_rsp(t + 3 + TIMEOUT + 1, 1'b1, {mem[2], 32'd0});
    @(negedge Clk); req_valid = 1'b0;
    wait_drain(60);
    acks_left = -1;

    // Read acknowledges during a write's waits must not advance it
    @(negedge Clk);
    send(1'b1, 2'd2, 64'hCAFEF00D12345678, t);
    push_norm(t, 1'b1, 2'd2, 64'hCAFEF00D12345678);
    @(negedge Clk); req_valid = 1'b0;
    @(negedge Clk); inj_rd = 1'b1;
    @(negedge Clk); inj_rd = 1'b0;
    @(negedge Clk);
    @(negedge Clk); inj_rd = 1'b1;
    @(negedge Clk); inj_rd = 1'b0;
    wait_drain(40);

    // Reset during HI_WAIT of a write abandons it
    wr_lat = 10;
    @(negedge Clk);
    send(1'b1, 2'd1, 64'h0BADC0DE0BADC0DE, t);
    push_strb(t + 1, 1'b1, 2'd0, 32'h0BADC0DE);
    @(negedge Clk); req_valid = 1'b0;
    @(negedge Clk); Rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("rst_mid_strobes", 64'({VMERdMem, VMEWrMem}), 64'd0);
      chk("rst_mid_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
      chk("rst_mid_addr", 64'(VMEAddr), 64'd0);
      chk("rst_mid_wdata", 64'(VMEWrData), 64'd0);
      chk("rst_mid_rdata", rsp_rdata, 64'd0);
    end
    Rst = 1'b0;
    wr_lat = 2;
    r = cyc;
    send(1'b1, 2'd3, 64'h7766554433221100, t2);
    chk("rst_reaccept", 64'(t2), 64'(r));
    push_norm(t2, 1'b1, 2'd3, 64'h7766554433221100);
    @(negedge Clk); req_valid = 1'b0;
    wait_drain(40);

    // Back-to-back requests with req_valid held high
    @(negedge Clk);
    send(1'b0, 2'd2, 64'd0, t);
    push_norm(t, 1'b0, 2'd2, 64'd0);
    @(negedge Clk);
    send(1'b1, 2'd1, 64'h0102030405060708, t2);
    chk("b2b_accept", 64'(t2), 64'(last_rsp_cyc + 1));
    chk("b2b_first_rsp", 64'(last_rsp_cyc), 64'(t + 5));
    push_norm(t2, 1'b1, 2'd1, 64'h0102030405060708);
    @(negedge Clk); req_valid = 1'b0;
    wait_drain(40);

    repeat (4) @(negedge Clk);
    chk("final_ready", 64'(req_ready), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
